// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multi-digit hex display scanner.
// Holds the active-low seven-segment code table, the blank pattern,
// counter-width sizing and the parameter legality check.
package hex_disp_pkg;

   // All segments off (active-low)
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low g..a codes, entry n is the glyph for hex digit n
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E,  // F
      7'h06,  // E
      7'h21,  // d
      7'h46,  // C
      7'h03,  // b
      7'h08,  // A
      7'h10,  // 9
      7'h00,  // 8
      7'h78,  // 7
      7'h02,  // 6
      7'h12,  // 5
      7'h19,  // 4
      7'h30,  // 3
      7'h24,  // 2
      7'h79,  // 1
      7'h40   // 0
   };

   // Width of a counter spanning 0..limit-1, never narrower than one bit
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

   // Legal parameter space of the scanner
   function automatic bit params_legal(input int digits, input int scan_div,
                                       input int blink_frames);
      return (digits >= 1) && (digits <= 8) && (scan_div >= 1) && (blink_frames >= 1);
   endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational 4-bit hex nibble to active-low 7-segment decoder.
// Latency: zero cycles (pure combinational lookup).
// Backpressure: none; output follows the input continuously.
module hex_seg_decode
   import hex_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Multi-digit hex display driver: scans DIGITS digits over one shared segment bus.
// Latency: seg/dig_sel are registered and lag the scan index by one cycle.
// Backpressure: ready drops after a load and returns at the next frame end commit.
module hex_display_scan
   import hex_disp_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
)
(
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   output logic                  ready,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int IDX_W   = cnt_width(DIGITS);
   localparam int SCAN_W  = cnt_width(SCAN_DIV);
   localparam int FRAME_W = cnt_width(BLINK_FRAMES);

   if (!params_legal(DIGITS, SCAN_DIV, BLINK_FRAMES)) begin : g_bad_params
      $error("hex_display_scan: illegal DIGITS/SCAN_DIV/BLINK_FRAMES");
   end

   logic [IDX_W-1:0]    idx;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [FRAME_W-1:0]  frame_cnt;
   logic                hidden;
   logic [4*DIGITS-1:0] pending;
   logic [4*DIGITS-1:0] display;

   logic                tick;
   logic                frame_end;
   logic [3:0]          cur_nib;
   logic [6:0]          cur_code;
   logic                lz_blank;

   assign tick      = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign frame_end = tick && (idx == IDX_W'(DIGITS - 1));

   // Select the scanned nibble and decide whether it is a blanked leading zero
   always_comb begin
      cur_nib  = display[{idx, 2'b00} +: 4];
      lz_blank = blank_lz && (idx != '0) && ((display >> {idx, 2'b00}) == '0);
   end

   hex_seg_decode u_decode (
      .nibble (cur_nib),
      .seg    (cur_code)
   );

   // Dwell counter and digit index; index wraps after the last digit
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (tick) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Blink phase: toggles every BLINK_FRAMES frames, held visible while disabled
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         frame_cnt <= '0;
         hidden    <= 1'b0;
      end else if (!blink_en) begin
         frame_cnt <= '0;
         hidden    <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            hidden    <= ~hidden;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Load handshake into pending; commit to display only on a frame boundary
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pending <= '0;
         display <= '0;
         ready   <= 1'b1;
      end else if (load && ready) begin
         pending <= data_in;
         ready   <= 1'b0;
      end else if (frame_end && !ready) begin
         display <= pending;
         ready   <= 1'b1;
      end
   end

   // Registered segment and digit-enable outputs for the current scan slot
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         seg     <= SEG_BLANK;
         dig_sel <= DIGITS'(1);
      end else begin
         seg     <= (hidden || lz_blank) ? SEG_BLANK : cur_code;
         dig_sel <= DIGITS'(1) << idx;
      end
   end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: a 4-digit scanner plus a 1-digit/1-cycle build,
// both checked every cycle against a frame-arithmetic reference model,
// with directed scenarios followed by randomized load/blank/blink traffic.
module tb_hex_display_scan;

   localparam int D     = 4;
   localparam int SD    = 4;
   localparam int BF    = 2;
   localparam int FRAME = D * SD;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = '0;
   logic        blank_lz = 1'b0;
   logic        blink_en = 1'b0;
   logic        ready;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;

   logic        load1 = 1'b0;
   logic [3:0]  data1 = '0;
   logic        ready1;
   logic [6:0]  seg1;
   logic [0:0]  dig_sel1;

   int n_cmp = 0;
   int n_bad = 0;

   // Glyphs for 0..F, active-low g..a
   logic [6:0] seg_ref [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference state: elapsed cycles since reset, frames seen while blinking
   int          cyc;
   logic        m_ready;
   logic [15:0] m_pend, m_disp;
   int          m_frames;
   logic        m1_ready;
   logic [3:0]  m1_pend, m1_disp;

   hex_display_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .load     (load),
      .data_in  (data_in),
      .ready    (ready),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .seg      (seg),
      .dig_sel  (dig_sel)
   );

   hex_display_scan #(.DIGITS(1), .SCAN_DIV(1), .BLINK_FRAMES(1)) dut1 (
      .clock    (clock),
      .resetn   (resetn),
      .load     (load1),
      .data_in  (data1),
      .ready    (ready1),
      .blank_lz (blank_lz),
      .blink_en (1'b0),
      .seg      (seg1),
      .dig_sel  (dig_sel1)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      cyc      = 0;
      m_ready  = 1'b1;
      m_pend   = '0;
      m_disp   = '0;
      m_frames = 0;
      m1_ready = 1'b1;
      m1_pend  = '0;
      m1_disp  = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_seg"},   32'(seg),      32'h7F);
      chk({tag, "_dig"},   32'(dig_sel),  32'h1);
      chk({tag, "_rdy"},   32'(ready),    32'h1);
      chk({tag, "_seg1"},  32'(seg1),     32'h7F);
      chk({tag, "_dig1"},  32'(dig_sel1), 32'h1);
      chk({tag, "_rdy1"},  32'(ready1),   32'h1);
   endtask

   // One clock: predict outputs from the pre-edge state, advance the model, compare
   task automatic step();
      int         di;
      bit         hid, lz, fe;
      logic [3:0] nib;
      logic [6:0] e_seg, e_seg1;
      logic [3:0] e_dig;
      di    = (cyc / SD) % D;
      hid   = ((m_frames / BF) % 2) == 1;
      nib   = 4'((m_disp >> (4 * di)) & 16'hF);
      lz    = blank_lz && (di > 0) && ((m_disp >> (4 * di)) == 16'h0);
      e_dig = 4'(1 << di);
      e_seg = (hid || lz) ? 7'h7F : seg_ref[nib];
      fe    = (cyc % FRAME) == (FRAME - 1);
      if (load && m_ready) begin
         m_pend  = data_in;
         m_ready = 1'b0;
      end else if (fe && !m_ready) begin
         m_disp  = m_pend;
         m_ready = 1'b1;
      end
      if (!blink_en) m_frames = 0;
      else if (fe)   m_frames++;
      e_seg1 = seg_ref[m1_disp];
      if (load1 && m1_ready) begin
         m1_pend  = data1;
         m1_ready = 1'b0;
      end else if (!m1_ready) begin
         m1_disp  = m1_pend;
         m1_ready = 1'b1;
      end
      cyc++;
      @(posedge clock);
      #1;
      chk("seg",   32'(seg),      32'(e_seg));
      chk("dig",   32'(dig_sel),  32'(e_dig));
      chk("ready", 32'(ready),    32'(m_ready));
      chk("seg1",  32'(seg1),     32'(e_seg1));
      chk("dig1",  32'(dig_sel1), 32'h1);
      chk("rdy1",  32'(ready1),   32'(m1_ready));
      load1 = ($urandom_range(0, 2) == 0);
      data1 = 4'($urandom);
   endtask

   task automatic load_value(input logic [15:0] v, input int hold);
      load    = 1'b1;
      data_in = v;
      repeat (hold) step();
      load    = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("rst");
      #3 resetn = 1'b1;

      // Plain value through the handshake, shown over two frames
      load_value(16'h12AF, 1);
      repeat (2 * FRAME) step();

      // Leading-zero blanking
      blank_lz = 1'b1;
      load_value(16'h0030, 1);
      repeat (2 * FRAME) step();
      load_value(16'h0000, 1);
      repeat (2 * FRAME) step();
      blank_lz = 1'b0;

      // Second load while busy is dropped
      load_value(16'h1111, 1);
      load_value(16'h2222, 3);
      repeat (2 * FRAME) step();

      // Load landing exactly on a frame_end cycle with ready high
      for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) step();
      load_value(16'hABCD, 1);
      repeat (2 * FRAME + 4) step();

      // Blink enabled from a frame boundary, then dropped
      for (int i = 0; i < FRAME && (cyc % FRAME) != 0; i++) step();
      blink_en = 1'b1;
      repeat (5 * FRAME) step();
      blink_en = 1'b0;
      repeat (8) step();

      // Asynchronous reset in the middle of a frame
      repeat (7) step();
      resetn = 1'b0;
      #2;
      check_reset_outputs("midrst");
      #1 resetn = 1'b1;
      model_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         load    = ($urandom_range(0, 3) == 0);
         data_in = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
Parametrised multi-digit hexadecimal display driver, the successor to the single-digit 4-bit-to-7-segment decoder. It holds a DIGITS-nibble value loaded through a ready/load handshake. It time-multiplexes one shared active-low segment bus across DIGITS one-hot digit enables, and adds leading-zero blanking and whole-display blinking. It sits between datapath/lab logic and the board's seven-segment displays.

Parameters:
DIGITS, 4, number of hex digits (1..8); data width is 4*DIGITS
SCAN_DIV, 50000, clock cycles each digit is driven before advancing (>=1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clock  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
load  in  1  request to load data_in; accepted only when ready=1
data_in  in  4*DIGITS  value to display; nibble k = digit k, digit 0 least significant
ready  out  1  high = no pending update; load is accepted this cycle
blank_lz  in  1  1 = blank leading zero digits
blink_en  in  1  1 = blink the whole display
seg  out  7  active-low segments, bit 0=a … bit 6=g (0 = lit)
dig_sel  out  DIGITS  one-hot active-high digit enable

Behaviour:
- Reset (async, resetn=0): seg=7'h7F, dig_sel=1 (digit 0), ready=1, pending=0, display=0, idx=0, scan_cnt=0, frame_cnt=0, blink phase=visible. Takes effect without a clock edge, including mid-frame.
- Segment codes, active-low g..a, for 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. Blank = 1111111.
- Scan: scan_cnt counts 0..SCAN_DIV-1. tick = (scan_cnt==SCAN_DIV-1). On tick, scan_cnt clears and idx advances, wrapping DIGITS-1 -> 0. frame_end = tick and idx==DIGITS-1.
- Outputs are registered. Every cycle, seg/dig_sel load the decode of the current idx/display/phase/controls, so they lag idx by exactly 1 cycle. dig_sel = 1<<idx. seg = code of display nibble idx, or blank.
- Handshake: at an edge with load=1 and ready=1, data_in is captured into pending and ready becomes 0. load with ready=0 is ignored; no error is flagged.
- Commit: at frame_end with ready=0, display<=pending and ready<=1. The display therefore never changes mid-frame.
- Simultaneous load and frame_end:
  - ready=1: capture to pending; commit occurs at the following frame_end.
  - ready=0: commit the old pending; the new load is ignored.
- Leading-zero blank: with blank_lz=1, digit k is blank if nibbles DIGITS-1..k are all 0 and k>0. Digit 0 is never blanked by this rule. blank_lz is sampled live.
- Blink, with blink_en=1:
  - frame_cnt counts frame_ends 0..BLINK_FRAMES-1, then wraps and toggles phase.
  - In the hidden phase, seg=blank for all digits; dig_sel keeps scanning.
  - blink_en=0 forces phase=visible and frame_cnt=0 at the next edge.
- Widths: counters sized with $clog2 of their limits, minimum 1 bit. No arithmetic overflow is possible beyond the defined wraps.

Decomposition:
- Package hex_disp_pkg: SEG_BLANK = 7'h7F, the 16-entry active-low segment code constant table, and a parameter-legality check macro/function.
- One sub-module, hex_seg_decode: combinational 4-bit to 7-bit active-low decoder, instantiated once on the scanned nibble. Blanking muxes stay in the parent.

Test Plan:
Common bench parameters: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset, then 3 cycles: seg=7'h7F, dig_sel=4'b0001, ready=1. Assert resetn=0 mid-frame: all outputs return to reset values before the next clock edge.
- load=1 with data_in=16'h12AF: ready=0 the next cycle and returns to 1 after frame_end. In the next frame, dig_sel 0001/0010/0100/1000 shows seg 0001110/0001000/0100100/1111001.
- blank_lz=1:
  - Load 16'h0030: digits 3 and 2 show 1111111, digit 1 shows 0110000, digit 0 shows 1000000.
  - Load 16'h0000: only digit 0 is lit, showing 1000000.
- Load 16'h1111, then load 16'h2222 while ready=0: display shows 1111 and the second load is dropped. A load asserted on the frame_end cycle with ready=1 commits at the following frame_end.
- blink_en=1 from a frame boundary: frames 0-1 show digits normally, frames 2-3 show seg=7'h7F with dig_sel still cycling. Dropping blink_en shows digits at once.
- SCAN_DIV=1 and DIGITS=1 builds: dig_sel constant 1, seg tracks display with 1-cycle latency, commit on every cycle after load.
